// File: rtl/usb_style_rx_destuffer_pkg.sv
// Shared constants and types for the receive-side bit destuffer.
package usb_style_rx_destuffer_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BIT_CNT_W   = 4;
  localparam int unsigned SYNC_W      = 8;
  localparam int unsigned STUFF_RUN   = 6;
  localparam int unsigned ONES_W      = 3;
  localparam int unsigned FRAME_WORDS = 4;
  localparam int unsigned WIF_W       = 3;
  localparam int unsigned WC_W        = 4;

  localparam logic [SYNC_W-1:0] SYNC_PAT = 8'b0111_1110;

  typedef enum logic {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } rx_state_e;

endpackage : usb_style_rx_destuffer_pkg

// File: rtl/usb_style_rx_destuffer_rx_bit_destuff.sv
// Tracks runs of consecutive 1s and classifies each received bit as data,
// a stuffed 0 to be dropped, or a stuffing violation.
module rx_bit_destuff
  import usb_style_rx_destuffer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_bit_en,
  input  logic i_bit,
  input  logic i_stuff_en,
  input  logic i_clear,
  output logic o_data_bit_c,
  output logic o_stuff_err_c
);

  logic [ONES_W-1:0] r_ones_cnt;
  logic [ONES_W-1:0] w_ones_nxt;
  logic              w_stuff_slot;

  // Classify the current bit and compute the next run length.
  always_comb begin
    w_stuff_slot  = i_stuff_en && (r_ones_cnt == ONES_W'(STUFF_RUN));
    o_data_bit_c  = i_bit_en && !w_stuff_slot;
    o_stuff_err_c = i_bit_en && w_stuff_slot && i_bit;
    w_ones_nxt    = r_ones_cnt;
    if (i_clear) begin
      w_ones_nxt = '0;
    end else if (i_bit_en) begin
      if (!i_stuff_en || w_stuff_slot || !i_bit) begin
        w_ones_nxt = '0;
      end else begin
        w_ones_nxt = r_ones_cnt + ONES_W'(1);
      end
    end
  end

  // Run-length register; persists across word boundaries within a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones_cnt <= '0;
    end else begin
      r_ones_cnt <= w_ones_nxt;
    end
  end

endmodule : rx_bit_destuff

// File: rtl/usb_style_rx_destuffer.sv
// Receive path: hunts for SYNC, destuffs the bit stream and deserialises
// LSB-first words, FRAME_WORDS per frame.
module usb_style_rx_destuffer
  import usb_style_rx_destuffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              SIE,
  input  logic              STUFF_OPER_rx,
  input  logic              bit_valid,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              sync_detect,
  output logic              stuff_err,
  output logic [WC_W-1:0]   word_count,
  output logic              busy
);

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [SYNC_W-1:0]    r_shift;
  logic [SYNC_W-1:0]    w_shift_in;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [WIF_W-1:0]     r_word_in_frame;
  logic [DATA_W-1:0]    r_assembly;
  logic [DATA_W-1:0]    w_assembly_nxt;
  logic                 r_word_done;
  logic                 w_consume;
  logic                 w_rx_bit_en;
  logic                 w_data_bit;
  logic                 w_stuff_err;
  logic                 w_sync_hit;
  logic                 w_word_done;
  logic                 w_frame_done;

  assign w_consume   = SIE & bit_valid;
  assign w_shift_in  = {r_shift[SYNC_W-2:0], serial_in};
  assign w_rx_bit_en = w_consume && (r_state == RECEIVE);
  assign busy        = (r_state == RECEIVE);

  rx_bit_destuff u_destuff (
    .clk           (clk),
    .rst           (rst),
    .i_bit_en      (w_rx_bit_en),
    .i_bit         (serial_in),
    .i_stuff_en    (STUFF_OPER_rx),
    .i_clear       (w_sync_hit),
    .o_data_bit_c  (w_data_bit),
    .o_stuff_err_c (w_stuff_err)
  );

  // Next-state and framing decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_sync_hit     = 1'b0;
    w_word_done    = 1'b0;
    w_frame_done   = 1'b0;
    w_assembly_nxt = r_assembly;
    w_assembly_nxt[r_bit_cnt] = serial_in;
    case (r_state)
      HUNT: begin
        if (w_consume && (w_shift_in == SYNC_PAT)) begin
          w_sync_hit  = 1'b1;
          w_state_nxt = RECEIVE;
        end
      end
      RECEIVE: begin
        if (w_stuff_err) begin
          w_state_nxt = HUNT;
        end else if (w_data_bit && (r_bit_cnt == BIT_CNT_W'(DATA_W - 1))) begin
          w_word_done = 1'b1;
          if (r_word_in_frame == WIF_W'(FRAME_WORDS - 1)) begin
            w_frame_done = 1'b1;
            w_state_nxt  = HUNT;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: sync shifter, word assembly, counters and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_word_in_frame <= '0;
      r_assembly      <= '0;
      r_word_done     <= 1'b0;
      data_out        <= '0;
      data_valid      <= 1'b0;
      sync_detect     <= 1'b0;
      stuff_err       <= 1'b0;
      word_count      <= '0;
    end else begin
      sync_detect <= w_sync_hit;
      stuff_err   <= w_stuff_err;
      r_word_done <= w_word_done;
      data_valid  <= r_word_done;

      if ((r_state == HUNT) && w_consume) begin
        r_shift <= w_shift_in;
      end
      if (w_stuff_err || w_frame_done) begin
        r_shift <= '0;
      end

      if (w_sync_hit || w_stuff_err) begin
        r_bit_cnt       <= '0;
        r_word_in_frame <= '0;
      end else if (w_data_bit) begin
        r_assembly <= w_assembly_nxt;
        if (w_word_done) begin
          data_out        <= w_assembly_nxt;
          word_count      <= word_count + WC_W'(1);
          r_bit_cnt       <= '0;
          r_word_in_frame <= w_frame_done ? '0 : r_word_in_frame + WIF_W'(1);
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

endmodule : usb_style_rx_destuffer

// File: doc/usb_style_rx_destuffer.md
Name: usb_style_rx_destuffer

Overview:
- Receive-side counterpart of the link transmitter.
- Hunts the serial line for the 8-bit SYNC pattern, then removes stuffed bits: a 0 follows every six consecutive 1s.
- Deserialises LSB-first 16-bit words and presents each as a parallel word with a one-cycle valid strobe, plus a running word counter.
- Sits between the line-side bit sampler and the packet/controller logic.

Parameters:
- DATA_W, 16, width of each deserialised word.
- SYNC_PAT, 8'b0111_1110, pattern that opens a frame; compared against the last 8 sampled bits.
- STUFF_RUN, 6, count of consecutive 1s after which a stuffed 0 is expected.
- FRAME_WORDS, 4, words received per frame before returning to hunt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- SIE  in  1  receiver enable; when 0 the block holds state and ignores the line
- STUFF_OPER_rx  in  1  1 = destuffing enabled; 0 = every bit is data, no stuff checks
- bit_valid  in  1  serial_in carries a sampled bit this cycle
- serial_in  in  1  sampled line bit
- data_out  out  DATA_W  last completed word, held until the next word completes
- data_valid  out  1  one-cycle strobe, the cycle after data_out updates
- sync_detect  out  1  one-cycle strobe when SYNC_PAT is matched
- stuff_err  out  1  one-cycle strobe on a stuffing violation
- word_count  out  4  wrapping count of words delivered since reset
- busy  out  1  1 while in RECEIVE

Behaviour:
- Reset (rst=1 at posedge):
  - state=HUNT; shift register, bit_cnt, ones_cnt, word_in_frame, data_out, word_count all 0.
  - data_valid, sync_detect, stuff_err, busy all 0.
- A bit is consumed only when SIE=1 and bit_valid=1. Otherwise all state holds and all strobes are 0.
- HUNT:
  - Shift serial_in into an 8-bit register, newest bit at LSB.
  - When the register value after the shift equals SYNC_PAT: pulse sync_detect next cycle, enter RECEIVE, clear bit_cnt, ones_cnt and word_in_frame.
  - No destuffing in HUNT.
- RECEIVE, with STUFF_OPER_rx=1:
  - If ones_cnt==STUFF_RUN, the current bit is the stuff bit:
    - 0: discard, ones_cnt=0, bit_cnt unchanged.
    - 1: pulse stuff_err, discard the partial word, return to HUNT (shift register cleared).
  - Otherwise the bit is data:
    - Write it to assembly[bit_cnt] (LSB first), then bit_cnt+1.
    - ones_cnt = bit ? ones_cnt+1 : 0.
- RECEIVE, with STUFF_OPER_rx=0: every bit is data; ones_cnt is held at 0.
- ones_cnt carries across word boundaries within a frame. A stuff bit owed at a word boundary is consumed before bit 0 of the next word.
- Word completion (data bit written at bit_cnt==DATA_W-1):
  - data_out <= full word on that edge; data_valid=1 on the following cycle only.
  - word_count+1 (wraps 15->0); bit_cnt=0; word_in_frame+1.
  - If word_in_frame reaches FRAME_WORDS, return to HUNT. If a stuff bit is still owed at that point, it is not checked.
- Latency: data_valid is high one cycle after the clock edge that samples the last data bit of the word.
- SIE dropping mid-word: freeze, then resume at the same bit position.
- Reset mid-frame: partial word is discarded; data_out returns to 0.
- A stuff error and word completion cannot coincide, because a stuff bit never carries data.

Decomposition:
- Shared package holds:
  - SYNC_PAT constant
  - state enum {HUNT, RECEIVE}
  - STUFF_RUN constant (shared with the transmitter)
- One natural sub-module, rx_bit_destuff: takes the bit stream and emits a data-bit qualifier and stuff_err. Instantiated by the top, which owns sync hunt, deserialisation and framing.

Test Plan:
- Reset, then SIE=1 with bits 0,1,1,1,1,1,1,0 -> sync_detect pulses once; busy=1.
- After sync, send 16'hA5C3 LSB first, no run of 6 ones -> data_out=16'hA5C3, data_valid for exactly 1 cycle, word_count=1.
- Send word 16'h003F with stuffed 0 after bit 5 (17 line bits) -> data_out=16'h003F; stuff bit not counted as data.
- Six 1s followed by a 1 mid-word -> stuff_err pulses, busy=0, no data_valid; a fresh SYNC then recovers and the next word is correct.
- STUFF_OPER_rx=0, word 16'hFFFF (16 bits, no stuffs) -> data_out=16'hFFFF, no stuff_err.
- FRAME_WORDS=4 back-to-back words, bit_valid toggled 1/0 with SIE low for 3 cycles mid-word -> 4 correct strobes, word_count=4, then busy=0 and the block is back in HUNT.
